// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operands LSB first, carry held in a register.
// Latency: done/sum_out/cout valid WIDTH cycles after start is sampled; one result per WIDTH+1 cycles back-to-back.
// Backpressure: start is only honoured in IDLE or DONE; requests while busy are ignored, no queuing.
module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  // Counter must index bits 0..WIDTH-1; a single-bit build still needs one bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_reg;
  logic [CW-1:0]    count;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // The only arithmetic in the block: one shared full-adder cell.
  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry_reg),
    .cout (fa_cout),
    .sum  (fa_sum)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  // Partial result only needs WIDTH-1 bits: the final bit comes straight from the adder
  // on the completing edge, so the register never holds a bit that is thrown away.
  if (WIDTH == 1) begin : g_single
    assign res_next = fa_sum;
  end else begin : g_multi
    logic [WIDTH-2:0] part_sh;
    logic [WIDTH-2:0] part_next;

    if (WIDTH == 2) begin : g_two
      assign part_next = fa_sum;
    end else begin : g_wide
      assign part_next = {fa_sum, part_sh[WIDTH-2:1]};
    end

    // Collect sum bits MSB-first-in so bit 0 ends up at the bottom after WIDTH-1 shifts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        part_sh <= '0;
      end else if (state == RUN) begin
        part_sh <= part_next;
      end
    end

    assign res_next = {fa_sum, part_sh};
  end

  // Control FSM with registered handshake outputs; operands captured from IDLE or DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      cout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh      <= a_in;
            b_sh      <= b_in;
            carry_reg <= cin;
            count     <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          carry_reg <= fa_cout;
          count     <= count + CW'(1);
          if (last_bit) begin
            sum_out <= res_next;
            cout    <= fa_cout;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh      <= a_in;
            b_sh      <= b_in;
            carry_reg <= cin;
            count     <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// One-bit full adder cell shared by the serial controller.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic cout,
  output logic sum
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: tb/tb_serial_adder_controller.sv
// Directed bench for the serial adder: WIDTH=8 and WIDTH=1 instances on one clock.
// Expected sums are pushed to a scoreboard queue at start and popped on each done pulse.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_serial_adder_controller;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum_out;
  logic       cout;

  logic       s1_start;
  logic [0:0] s1_a;
  logic [0:0] s1_b;
  logic       s1_cin;
  logic       s1_busy;
  logic       s1_done;
  logic [0:0] s1_sum;
  logic       s1_cout;

  int ncmp;
  int nmis;
  logic [8:0] sb[$];

  serial_adder_controller #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  serial_adder_controller #(.WIDTH(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (s1_start),
    .a_in    (s1_a),
    .b_in    (s1_b),
    .cin     (s1_cin),
    .busy    (s1_busy),
    .done    (s1_done),
    .sum_out (s1_sum),
    .cout    (s1_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected result and compare against the WIDTH=8 outputs.
  task automatic pop_check8(input string tag);
    logic [8:0] e;
    if (sb.size() == 0) begin
      ncmp++;
      nmis++;
      $error("FAIL %s: observed done with empty scoreboard expected a queued result", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, 32'(sum_out), 32'(e[7:0]));
      check({tag, "_cout"}, 32'(cout), 32'(e[8]));
    end
  endtask

  // One WIDTH=8 addition; optionally scramble start and operands while the block is running.
  task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input bit toggle);
    int got;
    sb.push_back(9'(a) + 9'(b) + 9'(ci));
    a_in  = a;
    b_in  = b;
    cin   = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      if (toggle && k <= 8) begin
        start = 1'($urandom_range(0, 1));
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        cin   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        got = k;
        break;
      end
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(got), 32'd8);
    pop_check8(tag);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d[2];
    int n;
    int ndone;
    logic [8:0] e1;
    logic [2:0] abc;

    ncmp     = 0;
    nmis     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    cin      = 1'b0;
    s1_start = 1'b0;
    s1_a     = '0;
    s1_b     = '0;
    s1_cin   = 1'b0;

    // Reset state of both builds.
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst1_busy", 32'(s1_busy), 32'd0);
    check("rst1_done", 32'(s1_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed single additions.
    do_add("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    do_add("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_add("3c_42", 8'h3C, 8'h42, 1'b0, 1'b0);
    do_add("a5_5a_toggle", 8'hA5, 8'h5A, 1'b1, 1'b1);

    // Back-to-back with start held high: second pair captured in the DONE cycle.
    sb.push_back(9'h030);
    a_in  = 8'h10;
    b_in  = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    sb.push_back(9'h101);
    a_in = 8'h80;
    b_in = 8'h80;
    cin  = 1'b1;
    n    = 0;
    d[0] = 0;
    d[1] = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        d[n] = k;
        pop_check8(n == 0 ? "b2b_first" : "b2b_second");
        n++;
        if (n == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(n), 32'd2);
    check("b2b_first_lat", 32'(d[0]), 32'd8);
    check("b2b_spacing", 32'(d[1] - d[0]), 32'd9);
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // Asynchronous abort partway through a run; last result (0x01/1) must be wiped.
    a_in  = 8'h11;
    b_in  = 8'h22;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum_out), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    do_add("after_abort", 8'h7F, 8'h01, 1'b1, 1'b0);

    // WIDTH=1 build: full-adder truth table, one-cycle run each.
    for (int i = 0; i < 8; i++) begin
      abc    = 3'(i);
      s1_a   = abc[2];
      s1_b   = abc[1];
      s1_cin = abc[0];
      sb.push_back(9'(abc[2]) + 9'(abc[1]) + 9'(abc[0]));
      s1_start = 1'b1;
      tick();
      s1_start = 1'b0;
      check("w1_busy", 32'(s1_busy), 32'd1);
      check("w1_done_early", 32'(s1_done), 32'd0);
      tick();
      check("w1_done", 32'(s1_done), 32'd1);
      check("w1_busy_done", 32'(s1_busy), 32'd0);
      if (sb.size() == 0) begin
        ncmp++;
        nmis++;
        $error("FAIL w1_result: observed done with empty scoreboard expected a queued result");
      end else begin
        e1 = sb.pop_front();
        check("w1_result", 32'({s1_cout, s1_sum}), 32'(e1[1:0]));
      end
    end
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
